if_id_stage: RTL

- IF/ID pipeline boundary directly downstream of the ifu fetch unit.
- Captures instr and pc8 each cycle and pre-decodes register and immediate fields for the decode stage.
- Detects load-use hazards and holds fetch through stall_if, which drives the ifu PC-hold input.
- Squashes the held instruction on a redirect (branchen/jalren taken) and counts inserted bubbles.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/hazard_detect.sv | 19 +
 rtl/if_id_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID boundary: NOP encoding, instruction field
// positions and the stall FSM encoding.
package pipe_pkg;

    // sll $0,$0,0
    localparam logic [31:0] NOP_ENC = 32'h0000_0000;

    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        EXT_STALL = 2'd2
    } if_id_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction held in IF/ID and a load in EX.
// Both source fields are compared regardless of opcode; the occasional false stall is accepted.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       in_run_i,
    output logic       lu_o
);

    // $0 is never a real dependency, so a load targeting it never stalls
    assign lu_o = in_run_i & valid_i & ex_memread_i & (ex_rt_i != REG_ZERO) &
                  ((ex_rt_i == rs_i) | (ex_rt_i == rt_i));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with field pre-decode, load-use / busy stalling,
// redirect squash and a saturating bubble counter.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter int unsigned     WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP  = WIDTH'(NOP_ENC),
    parameter int unsigned     CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc8_in,
    input  logic             fetch_valid,
    input  logic             flush,
    input  logic             ext_busy,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc8_out,
    output logic             valid_out,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm16,
    output logic             stall_if,
    output logic             bubble_out,
    output logic [CNT_W-1:0] bubble_cnt
);

    if_id_state_e     state_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc8_q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             lu;

    assign instr_out  = instr_q;
    assign pc8_out    = pc8_q;
    assign valid_out  = valid_q;
    assign bubble_cnt = bubble_cnt_q;

    assign rs    = instr_q[RS_MSB:RS_LSB];
    assign rt    = instr_q[RT_MSB:RT_LSB];
    assign rd    = instr_q[RD_MSB:RD_LSB];
    assign imm16 = instr_q[IMM_MSB:IMM_LSB];

    // Masking lu outside RUN makes the load-use penalty exactly one cycle
    hazard_detect u_hazard_detect (
        .valid_i      (valid_q),
        .ex_memread_i (ex_memread),
        .ex_rt_i      (ex_rt),
        .rs_i         (rs),
        .rt_i         (rt),
        .in_run_i     (state_q == RUN),
        .lu_o         (lu)
    );

    // Stall/bubble requests: flush overrides everything, busy overrides load-use
    always_comb begin
        stall_if   = reset & ~flush & (ext_busy | lu);
        bubble_out = reset & ~flush & ~ext_busy & lu;
    end

    // Pipeline register, stall FSM and saturating bubble counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            instr_q      <= NOP;
            pc8_q        <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            if (flush) begin
                instr_q <= NOP;
                valid_q <= 1'b0;
                pc8_q   <= pc8_in;
                state_q <= RUN;
            end else if (ext_busy) begin
                state_q <= EXT_STALL;
            end else if (lu) begin
                state_q <= LU_STALL;
            end else begin
                instr_q <= fetch_valid ? instr_in : NOP;
                valid_q <= fetch_valid;
                pc8_q   <= pc8_in;
                state_q <= RUN;
            end
            if (bubble_out && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
